car_motor_drive: RTL and testbench



---
 rtl/car_motor_drive.sv | 252 +++++++++++++++++++++++++
 tb/tb_car_motor_drive.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/car_motor_drive.sv
// car_motor_drive: turns go_front/go_left/go_right into PWM enable and
// direction outputs for two H-bridge driven wheels. Pivot turns last at least
// TURN_CYCLES, and every direction reversal passes through DEAD_CYCLES of
// PWM-off.
// Optional build macro: CAR_SOFTSTART_EN ramps the forward duty from 0 up to
// DUTY in RAMP_STEP increments, one increment per PWM period.
//
// state  | meaning
// STOP   | both wheels off, directions held
// FWD    | both wheels forward at PWM duty
// TURN_L | pivot left: left wheel reverse, right forward, for >= TURN_CYCLES
// TURN_R | pivot right: left forward, right reverse, for >= TURN_CYCLES
// DEAD   | PWM off before a direction change, then enter the latched target
module car_motor_drive #(
  parameter int PWM_BITS    = 8,
  parameter int DUTY        = 192,
  parameter int TURN_CYCLES = 16,
  parameter int DEAD_CYCLES = 4
`ifdef CAR_SOFTSTART_EN
  ,
  parameter int RAMP_STEP   = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic go_front,
  input  logic go_left,
  input  logic go_right,
  output logic pwm_l,
  output logic dir_l,
  output logic pwm_r,
  output logic dir_r,
  output logic turning,
  output logic busy
);

  localparam int CNT_MAX = (TURN_CYCLES > DEAD_CYCLES) ? TURN_CYCLES : DEAD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS:0] DUTY_V    = (PWM_BITS + 1)'(DUTY);

  typedef enum logic [2:0] {
    ST_STOP,
    ST_FWD,
    ST_TURN_L,
    ST_TURN_R,
    ST_DEAD
  } state_t;

  state_t            state_q, state_d;
  state_t            tgt_q, tgt_d;
  logic              tgt_dl_q, tgt_dl_d;
  logic              tgt_dr_q, tgt_dr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_cur_l_q, dir_cur_l_d;
  logic              dir_cur_r_q, dir_cur_r_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  logic pwm_l_q, pwm_l_d;
  logic dir_l_q, dir_l_d;
  logic pwm_r_q, pwm_r_d;
  logic dir_r_q, dir_r_d;
  logic turning_q, turning_d;
  logic busy_q, busy_d;

  state_t            cmd_state;
  logic              cmd_dl;
  logic              cmd_dr;
  logic              dir_change;
  logic              decide;
  logic              wheels_on;
  logic              pwm_on;
  logic [PWM_BITS:0] duty_eff;

  // Decode the command into a target state and its wheel direction pair.
  always_comb begin
    cmd_state = ST_STOP;
    cmd_dl    = dir_cur_l_q;
    cmd_dr    = dir_cur_r_q;
    unique case ({go_front, go_left, go_right})
      3'b100: begin
        cmd_state = ST_FWD;
        cmd_dl    = 1'b1;
        cmd_dr    = 1'b1;
      end
      3'b010: begin
        cmd_state = ST_TURN_L;
        cmd_dl    = 1'b0;
        cmd_dr    = 1'b1;
      end
      3'b001: begin
        cmd_state = ST_TURN_R;
        cmd_dl    = 1'b1;
        cmd_dr    = 1'b0;
      end
      default: begin
        cmd_state = ST_STOP;
      end
    endcase
  end

  assign dir_change = ({cmd_dl, cmd_dr} != {dir_cur_l_q, dir_cur_r_q});

  // Next-state logic: decode commands only when idle or at the end of a turn.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    tgt_dl_d    = tgt_dl_q;
    tgt_dr_d    = tgt_dr_q;
    cnt_d       = cnt_q;
    dir_cur_l_d = dir_cur_l_q;
    dir_cur_r_d = dir_cur_r_q;
    decide      = 1'b0;

    case (state_q)
      ST_STOP, ST_FWD: begin
        decide = 1'b1;
      end
      ST_TURN_L, ST_TURN_R: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          decide = 1'b1;
        end
      end
      ST_DEAD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Directions switch only here, while both wheels are still off.
          state_d     = tgt_q;
          dir_cur_l_d = tgt_dl_q;
          dir_cur_r_d = tgt_dr_q;
          if ((tgt_q == ST_TURN_L) || (tgt_q == ST_TURN_R)) begin
            cnt_d = TURN_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase

    if (decide) begin
      if (dir_change) begin
        state_d  = ST_DEAD;
        tgt_d    = cmd_state;
        tgt_dl_d = cmd_dl;
        tgt_dr_d = cmd_dr;
        cnt_d    = DEAD_LOAD;
      end else begin
        state_d = cmd_state;
        // Entering or re-commanding a turn restarts its minimum hold time.
        if ((cmd_state == ST_TURN_L) || (cmd_state == ST_TURN_R)) begin
          cnt_d = TURN_LOAD;
        end
      end
    end
  end

`ifdef CAR_SOFTSTART_EN
  logic [PWM_BITS:0]   ramp_q, ramp_d;
  logic [PWM_BITS+1:0] ramp_sum;

  // Forward duty ramp: cleared outside FWD, stepped at every PWM wrap.
  always_comb begin
    ramp_sum = {1'b0, ramp_q} + (PWM_BITS + 2)'(RAMP_STEP);
    ramp_d   = ramp_q;
    if (state_q != ST_FWD) begin
      ramp_d = '0;
    end else if (pwm_cnt_q == '1) begin
      if (ramp_sum >= {1'b0, DUTY_V}) begin
        ramp_d = DUTY_V;
      end else begin
        ramp_d = ramp_sum[PWM_BITS:0];
      end
    end
  end

  // Ramp register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  assign duty_eff = (state_q == ST_FWD) ? ramp_q : DUTY_V;
`else
  assign duty_eff = DUTY_V;
`endif

  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  assign wheels_on = (state_q == ST_FWD) || (state_q == ST_TURN_L) || (state_q == ST_TURN_R);
  assign pwm_on    = ({1'b0, pwm_cnt_q} < duty_eff);

  // Output values one cycle behind the state, so every output is a flop.
  always_comb begin
    pwm_l_d   = wheels_on && pwm_on;
    pwm_r_d   = wheels_on && pwm_on;
    dir_l_d   = dir_cur_l_q;
    dir_r_d   = dir_cur_r_q;
    turning_d = (state_q == ST_TURN_L) || (state_q == ST_TURN_R);
    busy_d    = (state_q == ST_TURN_L) || (state_q == ST_TURN_R) || (state_q == ST_DEAD);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STOP;
      tgt_q       <= ST_STOP;
      tgt_dl_q    <= 1'b1;
      tgt_dr_q    <= 1'b1;
      cnt_q       <= '0;
      dir_cur_l_q <= 1'b1;
      dir_cur_r_q <= 1'b1;
      pwm_cnt_q   <= '0;
      pwm_l_q     <= 1'b0;
      dir_l_q     <= 1'b1;
      pwm_r_q     <= 1'b0;
      dir_r_q     <= 1'b1;
      turning_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      tgt_dl_q    <= tgt_dl_d;
      tgt_dr_q    <= tgt_dr_d;
      cnt_q       <= cnt_d;
      dir_cur_l_q <= dir_cur_l_d;
      dir_cur_r_q <= dir_cur_r_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_l_q     <= pwm_l_d;
      dir_l_q     <= dir_l_d;
      pwm_r_q     <= pwm_r_d;
      dir_r_q     <= dir_r_d;
      turning_q   <= turning_d;
      busy_q      <= busy_d;
    end
  end

  assign pwm_l   = pwm_l_q;
  assign dir_l   = dir_l_q;
  assign pwm_r   = pwm_r_q;
  assign dir_r   = dir_r_q;
  assign turning = turning_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_car_motor_drive.sv
// Directed bench for car_motor_drive (default build, DUTY=192, 256-cycle
// period, 16-cycle turns, 4-cycle dead time). Expected output words are queued
// before each clock edge and compared after it.
module tb_car_motor_drive;

  localparam int S_STOP = 0;
  localparam int S_FWD  = 1;
  localparam int S_TL   = 2;
  localparam int S_TR   = 3;
  localparam int S_DEAD = 4;

  logic clk = 1'b0;
  logic rst;
  logic go_front;
  logic go_left;
  logic go_right;
  logic pwm_l, dir_l, pwm_r, dir_r, turning, busy;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pc          = 0;

  car_motor_drive dut (
    .clk      (clk),
    .rst      (rst),
    .go_front (go_front),
    .go_left  (go_left),
    .go_right (go_right),
    .pwm_l    (pwm_l),
    .dir_l    (dir_l),
    .pwm_r    (pwm_r),
    .dir_r    (dir_r),
    .turning  (turning),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Queue the outputs expected after the next edge, given the state the DUT
  // is in during the current cycle. pc is the PWM counter before that edge.
  task automatic push(input string tag, input int st, input logic dl, input logic dr);
    exp_t e;
    logic p;
    p     = (pc < 192);
    e.tag = tag;
    case (st)
      S_FWD:   e.exp = {p, 1'b1, p, 1'b1, 1'b0, 1'b0};
      S_TL:    e.exp = {p, 1'b0, p, 1'b1, 1'b1, 1'b1};
      S_TR:    e.exp = {p, 1'b1, p, 1'b0, 1'b1, 1'b1};
      S_DEAD:  e.exp = {1'b0, dl, 1'b0, dr, 1'b0, 1'b1};
      default: e.exp = {1'b0, dl, 1'b0, dr, 1'b0, 1'b0};
    endcase
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t       e;
    logic [5:0] obs;
    @(posedge clk);
    if (rst) pc = 0;
    else     pc = (pc + 1) % 256;
    #1;
    obs = {pwm_l, dir_l, pwm_r, dir_r, turning, busy};
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: got {pwm_l,dir_l,pwm_r,dir_r,turning,busy}=%b expected %b",
               e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic run(input string tag, input int st, input logic dl, input logic dr, input int n);
    for (int i = 0; i < n; i++) begin
      push(tag, st, dl, dr);
      tick();
    end
  endtask

  initial begin
    int highs;
    rst      = 1'b1;
    go_front = 1'b0;
    go_left  = 1'b0;
    go_right = 1'b0;
    tick();
    push("reset", S_STOP, 1'b1, 1'b1);
    tick();
    rst = 1'b0;

    // Forward straight from reset: no dead time, 192/256 duty.
    go_front = 1'b1;
    run("fwd_latency", S_STOP, 1'b1, 1'b1, 1);
    run("fwd", S_FWD, 1'b1, 1'b1, 4);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      push("fwd_pwm", S_FWD, 1'b1, 1'b1);
      tick();
      if (pwm_l === 1'b1) highs++;
    end
    vectors++;
    assert (highs === 192) else begin
      miscompares++;
      $error("FAIL fwd_high_count: got %0d expected %0d", highs, 192);
    end

    // One-cycle left pulse: dead time, 16-cycle turn ignoring go_right, back to FWD.
    go_front = 1'b0;
    go_left  = 1'b1;
    run("left_cmd", S_FWD, 1'b1, 1'b1, 1);
    go_left  = 1'b0;
    go_front = 1'b1;
    run("dead_to_tl", S_DEAD, 1'b1, 1'b1, 4);
    for (int i = 0; i < 16; i++) begin
      go_right = (i < 12) ? i[0] : 1'b0;
      push("turn_l", S_TL, 1'b0, 1'b1);
      tick();
    end
    go_right = 1'b0;
    run("dead_tl_to_fwd", S_DEAD, 1'b0, 1'b1, 4);
    run("back_fwd", S_FWD, 1'b1, 1'b1, 3);

    // Turn left, then hold go_right through the turn end and one full TURN_R.
    go_front = 1'b0;
    go_left  = 1'b1;
    run("left_cmd2", S_FWD, 1'b1, 1'b1, 1);
    go_left  = 1'b0;
    go_right = 1'b1;
    run("dead_to_tl2", S_DEAD, 1'b1, 1'b1, 4);
    run("turn_l2", S_TL, 1'b0, 1'b1, 16);
    run("dead_tl_to_tr", S_DEAD, 1'b0, 1'b1, 4);
    run("turn_r", S_TR, 1'b1, 1'b0, 16);
    go_right = 1'b0;
    run("turn_r_restart", S_TR, 1'b1, 1'b0, 16);
    run("stop_after_tr", S_STOP, 1'b1, 1'b0, 2);

    // From STOP with reversed right wheel, forward needs a dead time.
    go_front = 1'b1;
    run("stop_to_fwd", S_STOP, 1'b1, 1'b0, 1);
    run("dead_to_fwd", S_DEAD, 1'b1, 1'b0, 4);
    run("fwd2", S_FWD, 1'b1, 1'b1, 3);

    // Illegal command combination stops the wheels without touching dirs.
    go_front = 1'b0;
    go_left  = 1'b1;
    go_right = 1'b1;
    run("illegal_cmd", S_FWD, 1'b1, 1'b1, 1);
    run("illegal_stop", S_STOP, 1'b1, 1'b1, 3);
    go_left  = 1'b0;
    go_right = 1'b0;

    // Reset in the second DEAD cycle, then forward with no dead time.
    go_left = 1'b1;
    run("stop_to_tl", S_STOP, 1'b1, 1'b1, 1);
    go_left = 1'b0;
    run("dead_before_rst", S_DEAD, 1'b1, 1'b1, 1);
    rst = 1'b1;
    push("reset_mid_dead", S_STOP, 1'b1, 1'b1);
    tick();
    rst      = 1'b0;
    go_front = 1'b1;
    run("post_rst_latency", S_STOP, 1'b1, 1'b1, 1);
    run("post_rst_fwd", S_FWD, 1'b1, 1'b1, 4);
    go_front = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
